// File: rtl/cpu_run_sequencer.sv
// Autonomous job sequencer for the pipelined cpu: loads a program into instruction memory,
// runs the core for a fixed number of cycles, then streams a window of data memory out.
module cpu_run_sequencer #(
   parameter int IMEM_WORDS = 512,
   parameter int DMEM_WORDS = 1024,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [9:0]       prog_len,
   input  logic [CNT_W-1:0] run_cycles,
   input  logic [9:0]       dump_base,
   input  logic [10:0]      dump_len,
   input  logic             load_valid,
   input  logic [31:0]      load_data,
   output logic             load_ready,
   output logic             cpu_arst_n,
   output logic             cpu_enable,
   output logic [31:0]      addr_ext,
   output logic             wen_ext,
   output logic [31:0]      wdata_ext,
   output logic [31:0]      addr_ext_2,
   output logic             ren_ext_2,
   input  logic [31:0]      rdata_ext_2,
   output logic             dump_valid,
   output logic [31:0]      dump_data,
   input  logic             dump_ready,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_LOAD     = 3'd1;
   localparam logic [2:0] S_ARM      = 3'd2;
   localparam logic [2:0] S_RUN      = 3'd3;
   localparam logic [2:0] S_DUMP_RD  = 3'd4;
   localparam logic [2:0] S_DUMP_CAP = 3'd5;
   localparam logic [2:0] S_DUMP_OUT = 3'd6;
   localparam logic [2:0] S_DONE     = 3'd7;

   localparam logic [11:0] IMEM_LIM = 12'(IMEM_WORDS);
   localparam logic [11:0] DMEM_LIM = 12'(DMEM_WORDS);

   logic [2:0]       state_q, state_d;
   logic [9:0]       prog_len_q, prog_len_d;
   logic [CNT_W-1:0] run_cycles_q, run_cycles_d;
   logic [9:0]       dump_base_q, dump_base_d;
   logic [10:0]      dump_len_q, dump_len_d;
   logic [9:0]       idx_q, idx_d;
   logic [10:0]      j_q, j_d;
   logic [CNT_W-1:0] run_cnt_q, run_cnt_d;

   logic             load_ready_q, load_ready_d;
   logic             cpu_arst_n_q, cpu_arst_n_d;
   logic             cpu_enable_q, cpu_enable_d;
   logic [31:0]      addr_ext_q, addr_ext_d;
   logic             wen_ext_q, wen_ext_d;
   logic [31:0]      wdata_ext_q, wdata_ext_d;
   logic [31:0]      addr_ext_2_q, addr_ext_2_d;
   logic             ren_ext_2_q, ren_ext_2_d;
   logic             dump_valid_q, dump_valid_d;
   logic [31:0]      dump_data_q, dump_data_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic [11:0]      prog_len_ext;
   logic [11:0]      dump_end;
   logic             cfg_bad;
   logic [11:0]      dump_word;

   // Config is judged on the raw inputs so a bad job never leaves IDLE for LOAD.
   always_comb begin
      prog_len_ext = {2'b00, prog_len};
      dump_end     = {2'b00, dump_base} + {1'b0, dump_len};
      cfg_bad      = (prog_len_ext > IMEM_LIM) || (dump_end > DMEM_LIM);
   end

   always_comb begin
      state_d      = state_q;
      prog_len_d   = prog_len_q;
      run_cycles_d = run_cycles_q;
      dump_base_d  = dump_base_q;
      dump_len_d   = dump_len_q;
      idx_d        = idx_q;
      j_d          = j_q;
      run_cnt_d    = run_cnt_q;
      addr_ext_d   = addr_ext_q;
      wen_ext_d    = 1'b0;
      wdata_ext_d  = wdata_ext_q;
      dump_data_d  = dump_data_q;
      err_d        = err_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               prog_len_d   = prog_len;
               run_cycles_d = run_cycles;
               dump_base_d  = dump_base;
               dump_len_d   = dump_len;
               idx_d        = 10'd0;
               j_d          = 11'd0;
               run_cnt_d    = '0;
               err_d        = 1'b0;
               if (cfg_bad) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else if (prog_len == 10'd0) begin
                  state_d = S_ARM;
               end else begin
                  state_d = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            if (load_valid && load_ready_q) begin
               wen_ext_d   = 1'b1;
               addr_ext_d  = {20'd0, idx_q, 2'b00};
               wdata_ext_d = load_data;
               idx_d       = idx_q + 10'd1;
               if (idx_q + 10'd1 == prog_len_q) begin
                  state_d = S_ARM;
               end
            end
         end
         S_ARM: begin
            if (run_cycles_q != '0) begin
               run_cnt_d = run_cycles_q - 1'b1;
               state_d   = S_RUN;
            end else if (dump_len_q != 11'd0) begin
               state_d = S_DUMP_RD;
            end else begin
               state_d = S_DONE;
            end
         end
         S_RUN: begin
            // The counter is preloaded with run_cycles-1, so zero marks the last enabled cycle.
            if (run_cnt_q != '0) begin
               run_cnt_d = run_cnt_q - 1'b1;
            end else if (dump_len_q != 11'd0) begin
               state_d = S_DUMP_RD;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DUMP_RD: begin
            state_d = S_DUMP_CAP;
         end
         S_DUMP_CAP: begin
            dump_data_d = rdata_ext_2;
            state_d     = S_DUMP_OUT;
         end
         S_DUMP_OUT: begin
            if (dump_ready) begin
               j_d = j_q + 11'd1;
               if (j_q + 11'd1 < dump_len_q) begin
                  state_d = S_DUMP_RD;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Status outputs are registered from the next state so they line up with the state they describe.
   always_comb begin
      dump_word    = {2'b00, dump_base_q} + {1'b0, j_d};
      load_ready_d = (state_d == S_LOAD);
      cpu_enable_d = (state_d == S_RUN);
      ren_ext_2_d  = (state_d == S_DUMP_RD);
      dump_valid_d = (state_d == S_DUMP_OUT);
      busy_d       = (state_d != S_IDLE);
      done_d       = (state_d == S_DONE);
      addr_ext_2_d = addr_ext_2_q;
      if (state_d == S_DUMP_RD) begin
         addr_ext_2_d = {18'd0, dump_word, 2'b00};
      end
      cpu_arst_n_d = cpu_arst_n_q;
      if (state_d == S_RUN) begin
         cpu_arst_n_d = 1'b1;
      end else if ((state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_ARM)) begin
         cpu_arst_n_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         prog_len_q   <= '0;
         run_cycles_q <= '0;
         dump_base_q  <= '0;
         dump_len_q   <= '0;
         idx_q        <= '0;
         j_q          <= '0;
         run_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         prog_len_q   <= prog_len_d;
         run_cycles_q <= run_cycles_d;
         dump_base_q  <= dump_base_d;
         dump_len_q   <= dump_len_d;
         idx_q        <= idx_d;
         j_q          <= j_d;
         run_cnt_q    <= run_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         load_ready_q <= 1'b0;
         cpu_arst_n_q <= 1'b0;
         cpu_enable_q <= 1'b0;
         addr_ext_q   <= '0;
         wen_ext_q    <= 1'b0;
         wdata_ext_q  <= '0;
         addr_ext_2_q <= '0;
         ren_ext_2_q  <= 1'b0;
         dump_valid_q <= 1'b0;
         dump_data_q  <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         load_ready_q <= load_ready_d;
         cpu_arst_n_q <= cpu_arst_n_d;
         cpu_enable_q <= cpu_enable_d;
         addr_ext_q   <= addr_ext_d;
         wen_ext_q    <= wen_ext_d;
         wdata_ext_q  <= wdata_ext_d;
         addr_ext_2_q <= addr_ext_2_d;
         ren_ext_2_q  <= ren_ext_2_d;
         dump_valid_q <= dump_valid_d;
         dump_data_q  <= dump_data_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign load_ready = load_ready_q;
   assign cpu_arst_n = cpu_arst_n_q;
   assign cpu_enable = cpu_enable_q;
   assign addr_ext   = addr_ext_q;
   assign wen_ext    = wen_ext_q;
   assign wdata_ext  = wdata_ext_q;
   assign addr_ext_2 = addr_ext_2_q;
   assign ren_ext_2  = ren_ext_2_q;
   assign dump_valid = dump_valid_q;
   assign dump_data  = dump_data_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Directed bench for cpu_run_sequencer: program load, run window, memory dump, config errors
// and reset abort, with a small data-memory model behind the second external port.
module tb_cpu_run_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [9:0]  prog_len = '0;
   logic [15:0] run_cycles = '0;
   logic [9:0]  dump_base = '0;
   logic [10:0] dump_len = '0;
   logic        load_valid = 1'b0;
   logic [31:0] load_data = '0;
   logic        load_ready;
   logic        cpu_arst_n;
   logic        cpu_enable;
   logic [31:0] addr_ext;
   logic        wen_ext;
   logic [31:0] wdata_ext;
   logic [31:0] addr_ext_2;
   logic        ren_ext_2;
   logic [31:0] rdata_ext_2 = '0;
   logic        dump_valid;
   logic [31:0] dump_data;
   logic        dump_ready = 1'b0;
   logic        busy;
   logic        done;
   logic        err;

   int tests_run = 0;
   int tests_failed = 0;

   logic [31:0] dmem [0:1023];
   logic [31:0] prog [0:7];

   logic [31:0] wr_addr [$];
   logic [31:0] wr_data [$];
   logic [31:0] rd_addr [$];
   logic [31:0] dump_out [$];
   int          en_count = 0;
   int          en_rises = 0;
   logic        en_prev = 1'b0;

   cpu_run_sequencer #(.IMEM_WORDS(512), .DMEM_WORDS(1024), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .prog_len(prog_len), .run_cycles(run_cycles),
      .dump_base(dump_base), .dump_len(dump_len), .load_valid(load_valid), .load_data(load_data),
      .load_ready(load_ready), .cpu_arst_n(cpu_arst_n), .cpu_enable(cpu_enable),
      .addr_ext(addr_ext), .wen_ext(wen_ext), .wdata_ext(wdata_ext), .addr_ext_2(addr_ext_2),
      .ren_ext_2(ren_ext_2), .rdata_ext_2(rdata_ext_2), .dump_valid(dump_valid),
      .dump_data(dump_data), .dump_ready(dump_ready), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Data memory stand-in: one-cycle read latency behind ren_ext_2.
   always @(posedge clk) begin
      if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[11:2]];
   end

   // Passive monitor recording every memory access, dump handshake and enable cycle.
   always @(negedge clk) begin
      if (wen_ext) begin
         wr_addr.push_back(addr_ext);
         wr_data.push_back(wdata_ext);
      end
      if (ren_ext_2) rd_addr.push_back(addr_ext_2);
      if (dump_valid && dump_ready) dump_out.push_back(dump_data);
      if (cpu_enable) en_count++;
      if (cpu_enable && !en_prev) en_rises++;
      en_prev = cpu_enable;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [9:0] pl, input logic [15:0] rc,
                                input logic [9:0] db, input logic [10:0] dl);
      prog_len   = pl;
      run_cycles = rc;
      dump_base  = db;
      dump_len   = dl;
      start      = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic feedProgram(input int n, input bit gapped);
      int  k = 0;
      int  cyc = 0;
      bit  hs;
      while (k < n && cyc < 200) begin
         load_valid = gapped ? (cyc % 2 == 0) : 1'b1;
         load_data  = prog[k];
         @(negedge clk);
         hs = load_valid && load_ready;
         @(posedge clk);
         #1;
         if (hs) k++;
         cyc++;
      end
      load_valid = 1'b0;
      checkOutput("load_words", 32'(k), 32'(n));
   endtask

   task automatic waitDone(input string tag, input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      checkOutput(tag, 32'(seen), 32'd1);
   endtask

   initial begin
      int wb, rb, db, eb, rib;

      for (int i = 0; i < 1024; i++) dmem[i] = 32'h1000_0000 + 32'(i);
      dmem[2] = 32'h0000_000A;
      dmem[3] = 32'h0000_000B;
      dmem[4] = 32'h0000_000C;
      prog[0] = 32'h2001_0005;
      prog[1] = 32'h2002_0007;
      prog[2] = 32'h0022_1820;
      prog[3] = 32'hDEAD_BEEF;
      for (int i = 4; i < 8; i++) prog[i] = 32'h0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_arst_n", 32'(cpu_arst_n), 32'd0);
      checkOutput("rst_enable", 32'(cpu_enable), 32'd0);
      checkOutput("rst_load_ready", 32'(load_ready), 32'd0);
      checkOutput("rst_done_err", {30'd0, done, err}, 32'd0);
      checkOutput("rst_addr_ext", addr_ext, 32'd0);
      checkOutput("rst_dump_valid", 32'(dump_valid), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Job 1: three-word program, 12 run cycles, no dump
      wb = wr_addr.size(); eb = en_count; rib = en_rises;
      applyStimulus(10'd3, 16'd12, 10'd0, 11'd0);
      @(negedge clk);
      checkOutput("j1_busy", 32'(busy), 32'd1);
      checkOutput("j1_load_ready", 32'(load_ready), 32'd1);
      @(posedge clk);
      #1;
      feedProgram(3, 1'b0);
      waitDone("j1_done", 100);
      checkOutput("j1_nwrites", 32'(wr_addr.size() - wb), 32'd3);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("j1_waddr%0d", i), wr_addr[wb + i], 32'(4 * i));
         checkOutput($sformatf("j1_wdata%0d", i), wr_data[wb + i], prog[i]);
      end
      checkOutput("j1_en_cycles", 32'(en_count - eb), 32'd12);
      checkOutput("j1_en_rises", 32'(en_rises - rib), 32'd1);
      @(negedge clk);
      checkOutput("j1_done_pulse", 32'(done), 32'd0);
      checkOutput("j1_busy_after", 32'(busy), 32'd0);
      checkOutput("j1_arst_after", 32'(cpu_arst_n), 32'd0);

      // Job 2: four words with load_valid gapping every other cycle
      for (int i = 0; i < 4; i++) prog[i] = 32'hC0DE_0000 + 32'(i * 17);
      @(posedge clk);
      #1;
      wb = wr_addr.size();
      applyStimulus(10'd4, 16'd0, 10'd0, 11'd0);
      feedProgram(4, 1'b1);
      waitDone("j2_done", 50);
      checkOutput("j2_nwrites", 32'(wr_addr.size() - wb), 32'd4);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("j2_waddr%0d", i), wr_addr[wb + i], 32'(4 * i));
         checkOutput($sformatf("j2_wdata%0d", i), wr_data[wb + i], 32'hC0DE_0000 + 32'(i * 17));
      end

      // Job 3: dump words 2..4 with the consumer stalling 5 cycles on the first word
      @(posedge clk);
      #1;
      rb = rd_addr.size(); db = dump_out.size();
      dump_ready = 1'b0;
      applyStimulus(10'd0, 16'd2, 10'd2, 11'd3);
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (dump_valid) seen = 1'b1;
         end
         checkOutput("j3_first_valid", 32'(seen), 32'd1);
      end
      checkOutput("j3_stall0", dump_data, 32'h0000_000A);
      for (int i = 1; i < 5; i++) begin
         @(negedge clk);
         checkOutput($sformatf("j3_stall%0d", i), dump_data, 32'h0000_000A);
         checkOutput($sformatf("j3_stall_valid%0d", i), 32'(dump_valid), 32'd1);
      end
      @(posedge clk);
      #1 dump_ready = 1'b1;
      waitDone("j3_done", 60);
      checkOutput("j3_nreads", 32'(rd_addr.size() - rb), 32'd3);
      checkOutput("j3_raddr0", rd_addr[rb + 0], 32'd8);
      checkOutput("j3_raddr1", rd_addr[rb + 1], 32'd12);
      checkOutput("j3_raddr2", rd_addr[rb + 2], 32'd16);
      checkOutput("j3_ndump", 32'(dump_out.size() - db), 32'd3);
      checkOutput("j3_dump0", dump_out[db + 0], 32'h0000_000A);
      checkOutput("j3_dump1", dump_out[db + 1], 32'h0000_000B);
      checkOutput("j3_dump2", dump_out[db + 2], 32'h0000_000C);

      // Job 4: oversize program is rejected straight to DONE
      @(posedge clk);
      #1;
      wb = wr_addr.size(); eb = en_count;
      applyStimulus(10'd600, 16'd5, 10'd0, 11'd0);
      @(negedge clk);
      checkOutput("j4_err", 32'(err), 32'd1);
      checkOutput("j4_done", 32'(done), 32'd1);
      @(negedge clk);
      checkOutput("j4_err_sticky", 32'(err), 32'd1);
      checkOutput("j4_idle", 32'(busy), 32'd0);
      checkOutput("j4_nwrites", 32'(wr_addr.size() - wb), 32'd0);
      checkOutput("j4_en_cycles", 32'(en_count - eb), 32'd0);

      // Job 5: no program, no run, single dump word; also clears err
      @(posedge clk);
      #1;
      wb = wr_addr.size(); eb = en_count; rb = rd_addr.size(); db = dump_out.size();
      applyStimulus(10'd0, 16'd0, 10'd5, 11'd1);
      @(negedge clk);
      checkOutput("j5_err_cleared", 32'(err), 32'd0);
      waitDone("j5_done", 30);
      checkOutput("j5_nwrites", 32'(wr_addr.size() - wb), 32'd0);
      checkOutput("j5_en_cycles", 32'(en_count - eb), 32'd0);
      checkOutput("j5_raddr", rd_addr[rb], 32'd20);
      checkOutput("j5_ndump", 32'(dump_out.size() - db), 32'd1);
      checkOutput("j5_dump", dump_out[db], 32'h1000_0005);

      // Job 6: reset lands mid-RUN; a start while busy must be ignored
      @(posedge clk);
      #1;
      eb = en_count; wb = wr_addr.size();
      applyStimulus(10'd0, 16'd20, 10'd0, 11'd0);
      begin
         bit reached = 1'b0;
         for (int i = 0; i < 30 && !reached; i++) begin
            @(negedge clk);
            if (en_count - eb >= 5) reached = 1'b1;
         end
         checkOutput("j6_run_reached", 32'(reached), 32'd1);
      end
      prog_len = 10'd600;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      checkOutput("j6_busy_start_ignored", 32'(err), 32'd0);
      checkOutput("j6_still_enabled", 32'(cpu_enable), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("j6_rst_enable", 32'(cpu_enable), 32'd0);
      checkOutput("j6_rst_arst_n", 32'(cpu_arst_n), 32'd0);
      checkOutput("j6_rst_busy", 32'(busy), 32'd0);
      eb = en_count;
      repeat (4) @(negedge clk);
      checkOutput("j6_no_more_enable", 32'(en_count - eb), 32'd0);
      checkOutput("j6_no_writes", 32'(wr_addr.size() - wb), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/cpu_run_sequencer.md
Name: cpu_run_sequencer

Overview:
- Top-level sequencer for the 5-stage pipelined cpu. Fully autonomous: no software control.
- Runs one job as three phases:
  - Streams a program into instruction memory through the cpu external port (wen_ext/addr_ext/wdata_ext).
  - Releases the cpu from reset and asserts enable for a programmed number of cycles.
  - Freezes the cpu and streams a window of data memory out through the second external port (ren_ext_2/rdata_ext_2).
- Sits between the testbench/host stream interfaces and the cpu top.

Parameters:
- IMEM_WORDS, 512, instruction memory depth in words; prog_len above this is an error.
- DMEM_WORDS, 1024, data memory depth in words; dump window must fit.
- CNT_W, 16, width of run-cycle counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle job request; sampled only in IDLE.
- prog_len  in  10  instruction words to load; sampled on start.
- run_cycles  in  CNT_W  cpu enabled cycles; sampled on start.
- dump_base  in  10  first data-memory word index to dump; sampled on start.
- dump_len  in  11  data-memory words to dump; sampled on start.
- load_valid  in  1  program word available.
- load_data  in  32  program word.
- load_ready  out  1  sequencer accepts a program word.
- cpu_arst_n  out  1  drives cpu arst_n; low holds cpu in reset.
- cpu_enable  out  1  drives cpu enable.
- addr_ext  out  32  instruction-memory external address, byte address = word index × 4.
- wen_ext  out  1  instruction-memory external write enable.
- wdata_ext  out  32  instruction-memory external write data.
- addr_ext_2  out  32  data-memory external address, byte address.
- ren_ext_2  out  1  data-memory external read enable.
- rdata_ext_2  in  32  data-memory read data; valid the cycle after ren_ext_2.
- dump_valid  out  1  dump word valid.
- dump_data  out  32  dump word.
- dump_ready  in  1  consumer accepts dump word.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at job end.
- err  out  1  sticky config error; cleared by next accepted start.

Behaviour:
- Reset values:
  - All outputs registered.
  - On rst: state IDLE, cpu_arst_n=0, cpu_enable=0, load_ready=0, wen_ext=0, ren_ext_2=0, dump_valid=0, busy=0, done=0, err=0.
  - All address/data outputs 0, all counters 0.
  - rst in any state aborts the job within one cycle; no further memory writes are issued.
- States: IDLE, LOAD, ARM, RUN, DUMP_RD, DUMP_CAP, DUMP_OUT, DONE.
- IDLE:
  - cpu_arst_n=0.
  - start=1 latches config, clears err, then branches:
    - prog_len > IMEM_WORDS or dump_base+dump_len > DMEM_WORDS → err=1, go to DONE.
    - prog_len=0 → ARM.
    - otherwise → LOAD.
  - start in any other state is ignored.
- LOAD:
  - load_ready=1, cpu_arst_n=0.
  - Each valid&ready handshake causes, in the next cycle, wen_ext=1, addr_ext=idx<<2, wdata_ext=load_data; idx then increments.
  - wen_ext is otherwise 0.
  - After handshake idx=prog_len-1: load_ready drops the next cycle and the state goes to ARM.
  - Gaps in load_valid stall without limit.
- ARM:
  - Exactly one cycle. The final write is issued in this cycle; cpu_arst_n stays 0.
  - Next state: RUN if run_cycles≠0, else DUMP_RD if dump_len≠0, else DONE.
- RUN:
  - cpu_arst_n=1, cpu_enable=1 for exactly run_cycles consecutive cycles; counter counts down to 0.
  - Then cpu_enable=0 with cpu_arst_n held at 1, so the pipeline and memory state stay frozen.
  - Go to DUMP_RD, or DONE if dump_len=0.
- DUMP_RD: ren_ext_2=1 for one cycle, addr_ext_2=(dump_base+j)<<2.
- DUMP_CAP: capture rdata_ext_2 into dump_data.
- DUMP_OUT:
  - dump_valid=1; dump_data held stable until dump_ready.
  - On handshake j increments; go to DUMP_RD if j<dump_len, else DONE.
  - Minimum cost is 3 cycles per word.
- DONE:
  - done=1 for one cycle, then IDLE.
  - cpu_arst_n returns to 0 in IDLE.
  - err persists until the next accepted start.
- Counters wrap-free:
  - idx counts to prog_len, j counts to dump_len, run counter loaded from run_cycles.
  - Maximum values fit their widths.

Test Plan:
- prog_len=3 with words 0x20010005,0x20020007,0x00221820; run_cycles=12; dump_len=0 → wen_ext pulses at addr 0,4,8 with those data; cpu_enable high exactly 12 cycles; done pulse; busy low after.
- load_valid toggled 1/0/1 with prog_len=4 → exactly 4 writes at addr 0..12, data in order; no write in stall cycles.
- Dump with dump_base=2, dump_len=3, DMEM words 2..4 = 0xA,0xB,0xC, dump_ready low 5 cycles on word 2 → addr_ext_2 = 8,12,16; outputs 0xA,0xB,0xC; dump_data stable while stalled.
- prog_len=600 → err=1, done pulse within 2 cycles, no wen_ext, cpu_enable never high; next valid start clears err.
- prog_len=0, run_cycles=0, dump_len=1 → no writes, no enable cycles, one dump word, done.
- rst asserted mid-RUN after 5 of 20 cycles → next cycle cpu_enable=0, cpu_arst_n=0, busy=0; start during busy is ignored.
